econet_collision_detect: RTL and testbench
==========================================

// Module: econet_collision_detect
// PURPOSE
//  Econet collision detector clocked from the raw 12 MHz input_clk, independent of the PLL.
//  Drives collision_ref_pwm with a first-order sigma-delta stream; the external 1k/100nF RC
//  turns it into the comparator reference.
//  Samples the comparator (collision_detect) while econet_tx_enable is high.
//  Raises a sticky collision flag for the CPU-side econet_collision_intr.
//  Configuration and acknowledge arrive from econet_hwctl (clk domain) via toggle handshakes.
// PARAMETERS
//  PWM_BITS     8   width of ref_level and of the sigma-delta accumulator
//  FILTER_LEN   16  consecutive high samples needed to declare a collision (1..255)
//  BLANK_CYCLES 64  input_clk cycles ignored after tx start, for comparator/line settling (1..65535)
//  SYNC_STAGES  2   flip-flop depth of every async-input synchroniser (>=2)
// PORTS
//  input_clk          in   1         free-running 12 MHz clock
//  reset              in   1         asynchronous, active-high
//  cfg_ref_level      in   PWM_BITS  reference duty (clk domain, quasi-static)
//  cfg_enable         in   1         detector enable (clk domain, quasi-static)
//  cfg_load_toggle    in   1         any edge = capture cfg_ref_level and cfg_enable
//  ack_toggle         in   1         any edge = clear collision flag
//  transmitting       in   1         async; high while the tx block drives the line
//  collision_detect   in   1         async comparator output; high = line disagreement
//  collision_ref_pwm  out  1         sigma-delta reference stream
//  collision_flag     out  1         sticky collision, registered level; CPU side re-synchronises
//  collision_count    out  8         saturating collision count since reset
// BEHAVIOUR
//  Synchronisers
//  - transmitting, collision_detect, cfg_load_toggle, ack_toggle each pass SYNC_STAGES flops.
//  - A toggle event is sync_out XOR its previous value: one pulse per edge, either polarity.
//  Config capture
//  - On a cfg event, ref_q <= cfg_ref_level and en_q <= cfg_enable.
//  - The sender holds the cfg_* values stable from 1 input_clk before the toggle
//    until SYNC_STAGES+2 input_clk after it.
//  - Reset values: ref_q = 2^(PWM_BITS-1) (0x80), en_q = 0.
//  Sigma-delta PWM
//  - acc is PWM_BITS+1 bits. Each cycle: {carry, acc} <= acc[PWM_BITS-1:0] + ref_q.
//  - collision_ref_pwm = registered carry.
//  - Mean duty is ref_q/2^PWM_BITS: ref_q=0 gives constant 0; 0xFF gives 255 highs per 256 cycles.
//  - A new ref_q takes effect on the next add; acc is not cleared. PWM runs even when en_q = 0.
//  State machine (st) and sample counter (cnt); the blank and filter phases share cnt
//  - IDLE:    cnt <= 0. Go to BLANK when en_q & tx_s.
//  - BLANK:   cnt += 1. Go to ARMED when cnt == BLANK_CYCLES-1, clearing cnt.
//             Go to IDLE if !tx_s | !en_q.
//  - ARMED:   cnt += 1 when cd_s = 1, else cnt <= 0.
//             When cnt == FILTER_LEN-1 and cd_s = 1: collision_flag <= 1,
//             collision_count += 1 (saturates at 0xFF), go to LATCHED.
//             Go to IDLE if !tx_s | !en_q.
//  - LATCHED: no further sampling. Go to IDLE when !tx_s.
//             One detection per transmission, so the tx block sees a stable flag.
//  - Flag clear: an ack event sets collision_flag <= 0 in any state.
//  - Ack event in the same cycle as a detection: the detection wins, the flag stays 1,
//    and the count still increments.
//  - Latency from the collision_detect edge to collision_flag high:
//    SYNC_STAGES + FILTER_LEN cycles, measured from an ARMED state with cnt = 0.
//  - Deasserting en_q forces IDLE and clears cnt; it never clears collision_flag.
//  Reset (async, any state)
//  - st = IDLE, cnt = 0, acc = 0, collision_ref_pwm = 0, collision_flag = 0,
//    collision_count = 0, all synchroniser and toggle-history flops = 0.
//  - Synchronisers restart from 0 after reset, so a toggle input already high
//    produces one spurious event.
//  - The sender issues cfg_load_toggle after reset, which makes this event harmless.
// TESTING
//  1. Reset, no cfg load:
//     -> pwm duty exactly 128/256 over 256 cycles; flag=0; count=0.
//  2. Load ref=0x00, then 0xFF, then 0x40:
//     -> 0, 255 and 64 highs per 256-cycle window; the first window after a change is excluded.
//  3. en=1, transmitting=1, collision_detect=1 from tx start:
//     -> no flag before BLANK_CYCLES; flag=1 exactly SYNC_STAGES+FILTER_LEN cycles
//        after ARMED is entered; count=1.
//  4. In ARMED, collision_detect high for 15 cycles, low for 1, then high for 16:
//     -> flag rises only after the second run; count=1.
//  5. Flag=1, ack toggle lands on the cycle of a new detection (second tx):
//     -> flag stays 1, count=2. A later ack alone -> flag=0.
//  6. Assert reset mid-ARMED with cnt=10:
//     -> all outputs 0 immediately; after release, st=IDLE and 128/256 pwm resumes.
//     Also force 300 detections -> count saturates at 0xFF.

Source files
------------

// File: rtl/econet_collision_if.sv
// Econet collision detector signal bundle: config/ack toggles from the hwctl side,
// async line inputs, and the detector outputs.
interface econet_collision_if #(
  parameter int PWM_BITS = 8
);
  logic [PWM_BITS-1:0] cfg_ref_level;
  logic                cfg_enable;
  logic                cfg_load_toggle;
  logic                ack_toggle;
  logic                transmitting;
  logic                collision_detect;
  logic                collision_ref_pwm;
  logic                collision_flag;
  logic [7:0]          collision_count;

  modport master (
    output cfg_ref_level, cfg_enable, cfg_load_toggle, ack_toggle,
           transmitting, collision_detect,
    input  collision_ref_pwm, collision_flag, collision_count
  );

  modport slave (
    input  cfg_ref_level, cfg_enable, cfg_load_toggle, ack_toggle,
           transmitting, collision_detect,
    output collision_ref_pwm, collision_flag, collision_count
  );
endinterface

// File: rtl/econet_collision_detect.sv
// Econet collision detector on the raw input_clk: sigma-delta comparator reference,
// blanked + filtered comparator sampling during tx, sticky flag and saturating count.
module econet_collision_detect #(
  parameter int PWM_BITS     = 8,
  parameter int FILTER_LEN   = 16,
  parameter int BLANK_CYCLES = 64,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              input_clk,
  input  logic              reset,
  econet_collision_if.slave bus
);

  localparam logic [15:0] BLANK_LAST  = 16'(BLANK_CYCLES - 1);
  localparam logic [15:0] FILTER_LAST = 16'(FILTER_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ARMED, S_LATCHED} st_t;

  // bit 0 tx, 1 comparator, 2 cfg toggle, 3 ack toggle
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic                        tx_s, cd_s, cfg_s, ack_s;
  logic                        cfg_hist_q, ack_hist_q;
  logic                        cfg_ev, ack_ev;

  logic [PWM_BITS-1:0] ref_q;
  logic                en_q;
  logic [PWM_BITS-1:0] acc_q;
  logic [PWM_BITS:0]   acc_d;
  logic                pwm_q;

  st_t         st_q;
  logic [15:0] cnt_q;
  logic        flag_q;
  logic [7:0]  count_q;

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      cfg_hist_q <= 1'b0;
      ack_hist_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0],
                     {bus.ack_toggle, bus.cfg_load_toggle, bus.collision_detect, bus.transmitting}};
      cfg_hist_q <= cfg_s;
      ack_hist_q <= ack_s;
    end
  end

  assign tx_s   = sync_q[SYNC_STAGES-1][0];
  assign cd_s   = sync_q[SYNC_STAGES-1][1];
  assign cfg_s  = sync_q[SYNC_STAGES-1][2];
  assign ack_s  = sync_q[SYNC_STAGES-1][3];
  assign cfg_ev = cfg_s ^ cfg_hist_q;
  assign ack_ev = ack_s ^ ack_hist_q;

  // cfg_* are held stable by the sender across the sync window, so direct capture is safe
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      ref_q <= {1'b1, {(PWM_BITS-1){1'b0}}};
      en_q  <= 1'b0;
    end else if (cfg_ev) begin
      ref_q <= bus.cfg_ref_level;
      en_q  <= bus.cfg_enable;
    end
  end

  assign acc_d = {1'b0, acc_q} + {1'b0, ref_q};

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      acc_q <= acc_d[PWM_BITS-1:0];
      pwm_q <= acc_d[PWM_BITS];
    end
  end

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      st_q    <= S_IDLE;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      count_q <= '0;
    end else begin
      // a detection in the same cycle overrides this clear below
      if (ack_ev) flag_q <= 1'b0;
      case (st_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (en_q && tx_s) st_q <= S_BLANK;
        end
        S_BLANK: begin
          if (!tx_s || !en_q) begin
            st_q  <= S_IDLE;
            cnt_q <= '0;
          end else if (cnt_q == BLANK_LAST) begin
            st_q  <= S_ARMED;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_ARMED: begin
          if (!tx_s || !en_q) begin
            st_q  <= S_IDLE;
            cnt_q <= '0;
          end else if (!cd_s) begin
            cnt_q <= '0;
          end else if (cnt_q == FILTER_LAST) begin
            flag_q <= 1'b1;
            if (count_q != 8'hFF) count_q <= count_q + 8'd1;
            st_q  <= S_LATCHED;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_LATCHED: begin
          // held until tx ends so the tx block sees one stable detection
          if (!tx_s || !en_q) st_q <= S_IDLE;
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

  assign bus.collision_ref_pwm = pwm_q;
  assign bus.collision_flag    = flag_q;
  assign bus.collision_count   = count_q;

endmodule

// File: tb/tb_econet_collision_detect.sv
// Directed bench for econet_collision_detect: pwm duty windows, blank/filter timing,
// ack/detection race, async reset and count saturation.
module tb_econet_collision_detect;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   h;

  always #5 clk = ~clk;

  econet_collision_if #(.PWM_BITS(8)) bus();

  econet_collision_detect #(
    .PWM_BITS(8), .FILTER_LEN(16), .BLANK_CYCLES(64), .SYNC_STAGES(2)
  ) dut (
    .input_clk (clk),
    .reset     (rst),
    .bus       (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pwm_highs(output int n);
    n = 0;
    for (int i = 0; i < 256; i++) begin
      tick(1);
      n += int'(bus.collision_ref_pwm);
    end
  endtask

  task automatic load(input logic [7:0] r, input logic e);
    bus.cfg_ref_level = r;
    bus.cfg_enable    = e;
    tick(1);
    bus.cfg_load_toggle = ~bus.cfg_load_toggle;
    tick(5);
  endtask

  task automatic ack();
    bus.ack_toggle = ~bus.ack_toggle;
  endtask

  initial begin
    bus.cfg_ref_level    = 8'h80;
    bus.cfg_enable       = 1'b0;
    bus.cfg_load_toggle  = 1'b0;
    bus.ack_toggle       = 1'b0;
    bus.transmitting     = 1'b0;
    bus.collision_detect = 1'b0;

    // 1: reset state, default 0x80 duty
    tick(3);
    chk("rst_pwm",   32'(bus.collision_ref_pwm), 0);
    chk("rst_flag",  32'(bus.collision_flag), 0);
    chk("rst_count", 32'(bus.collision_count), 0);
    rst = 1'b0;
    tick(4);
    pwm_highs(h);
    chk("duty_80_default", 32'(h), 128);

    // 2: duty windows, first window after each change skipped
    load(8'h00, 1'b0); tick(256); pwm_highs(h); chk("duty_00", 32'(h), 0);
    load(8'hFF, 1'b0); tick(256); pwm_highs(h); chk("duty_ff", 32'(h), 255);
    load(8'h40, 1'b0); tick(256); pwm_highs(h); chk("duty_40", 32'(h), 64);

    // 3: comparator high from tx start; 2 sync + 1 idle + 64 blank + 16 filter = edge 83
    load(8'h80, 1'b1);
    bus.transmitting     = 1'b1;
    bus.collision_detect = 1'b1;
    tick(82);
    chk("blank_no_flag", 32'(bus.collision_flag), 0);
    tick(1);
    chk("first_det_flag",  32'(bus.collision_flag), 1);
    chk("first_det_count", 32'(bus.collision_count), 1);

    // 4: 15-high run broken by one low, then a full run
    ack(); tick(3);
    chk("ack_clear", 32'(bus.collision_flag), 0);
    bus.transmitting     = 1'b0;
    bus.collision_detect = 1'b0;
    tick(5);
    bus.transmitting = 1'b1;
    tick(80);
    bus.collision_detect = 1'b1; tick(15);
    bus.collision_detect = 1'b0; tick(1);
    bus.collision_detect = 1'b1; tick(17);
    chk("run15_no_flag", 32'(bus.collision_flag), 0);
    tick(1);
    chk("run16_flag",  32'(bus.collision_flag), 1);
    chk("run16_count", 32'(bus.collision_count), 2);

    // 5: ack event lands on the detection edge of the next tx (edge 83)
    bus.transmitting = 1'b0;
    tick(5);
    bus.transmitting = 1'b1;
    tick(80);
    ack();
    tick(3);
    chk("race_flag",  32'(bus.collision_flag), 1);
    chk("race_count", 32'(bus.collision_count), 3);
    ack();
    tick(2);
    chk("ack_pending_flag", 32'(bus.collision_flag), 1);
    tick(1);
    chk("ack_alone_flag", 32'(bus.collision_flag), 0);

    // 6: async reset in ARMED with cnt = 10
    bus.transmitting     = 1'b0;
    tick(5);
    bus.collision_detect = 1'b0;
    bus.transmitting     = 1'b1;
    tick(80);
    bus.collision_detect = 1'b1;
    tick(12);
    rst = 1'b1;
    #1;
    chk("midrst_pwm",   32'(bus.collision_ref_pwm), 0);
    chk("midrst_flag",  32'(bus.collision_flag), 0);
    chk("midrst_count", 32'(bus.collision_count), 0);
    bus.cfg_ref_level = 8'h80;
    bus.cfg_enable    = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(6);
    pwm_highs(h);
    chk("post_rst_duty", 32'(h), 128);
    chk("post_rst_idle_flag", 32'(bus.collision_flag), 0);

    // saturation: one detection per tx burst
    bus.transmitting = 1'b0;
    tick(5);
    load(8'h80, 1'b1);
    for (int i = 1; i <= 300; i++) begin
      bus.transmitting = 1'b1;
      tick(85);
      bus.transmitting = 1'b0;
      tick(4);
      if (i == 10)  chk("sat_count_10",  32'(bus.collision_count), 10);
      if (i == 255) chk("sat_count_255", 32'(bus.collision_count), 255);
    end
    chk("sat_count_300", 32'(bus.collision_count), 255);
    chk("sat_flag",      32'(bus.collision_flag), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
